acorn_sequencer: RTL

- Top-level phase controller for the bit-serial ACORN-128 datapath built around state_update128.
- Sequences state clear, 1792-step key/IV initialization, associated-data absorption and padding, plaintext encryption and padding, and 768-step finalization.
- Drives step_en/ca/cb/mbit to the datapath and consumes its keystream bit. Exchanges AD, plaintext and ciphertext bits with the host via valid/ready.

---
 rtl/acorn_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/acorn_sequencer.sv
// rtl/acorn_sequencer.sv - phase controller for the bit-serial ACORN-128 datapath
//
// Sequences state clear, key/IV initialization, AD absorption and padding,
// plaintext encryption and padding, and finalization with tag capture.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    begin a run (accepted in IDLE or DONE only)
//   key_in, iv_in            128-bit key and IV, stable while busy
//   ad_len, pt_len           AD / plaintext lengths in bits, latched on start
//   ad_valid/ad_bit/ad_ready host AD bit stream
//   pt_valid/pt_bit/pt_ready host plaintext bit stream
//   ks_bit                   keystream bit from the datapath (combinational)
//   ct_bit, ct_valid         ciphertext bit stream to the host
//   state_clr, step_en       datapath clear / advance controls
//   ca_out, cb_out, mbit_out datapath step controls
//   busy                     high in every state except IDLE and DONE
//   tag_out, tag_valid       authentication tag, valid in DONE
module acorn_sequencer #(
  parameter int LEN_W       = 16,
  parameter int INIT_STEPS  = 1792,
  parameter int PAD_STEPS   = 256,
  parameter int FINAL_STEPS = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key_in,
  input  logic [127:0]     iv_in,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] pt_len,
  input  logic             ad_valid,
  input  logic             ad_bit,
  output logic             ad_ready,
  input  logic             pt_valid,
  input  logic             pt_bit,
  output logic             pt_ready,
  input  logic             ks_bit,
  output logic             ct_bit,
  output logic             ct_valid,
  output logic             state_clr,
  output logic             step_en,
  output logic             ca_out,
  output logic             cb_out,
  output logic             mbit_out,
  output logic             busy,
  output logic [127:0]     tag_out,
  output logic             tag_valid
);

  localparam int K_W = 11;
  localparam logic [K_W-1:0] INIT_LAST  = K_W'(INIT_STEPS - 1);
  localparam logic [K_W-1:0] PAD_LAST   = K_W'(PAD_STEPS - 1);
  localparam logic [K_W-1:0] FINAL_LAST = K_W'(FINAL_STEPS - 1);
  localparam logic [K_W-1:0] TAG_BASE   = K_W'(FINAL_STEPS - 128);
  localparam logic [K_W-1:0] PAD_CA_END = K_W'(128);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_INIT, S_AD, S_AD_PAD, S_ENC, S_ENC_PAD, S_FINAL, S_DONE
  } state_t;

  state_t           state, next_state;
  logic [K_W-1:0]   k;
  logic [LEN_W-1:0] msg_cnt;
  logic [LEN_W-1:0] ad_len_q, pt_len_q;
  logic [127:0]     tag_q;
  logic             init_mbit;

  // Key for the first 128 steps, IV for the next 128, one inverted key bit
  // at step 256, then the key repeated. k[6:0] is k mod 128.
  always_comb begin
    init_mbit = key_in[k[6:0]];
    if (k >= K_W'(128) && k < K_W'(256)) init_mbit = iv_in[k[6:0]];
    else if (k == K_W'(256))             init_mbit = ~key_in[0];
  end

  always_comb begin
    next_state = state;
    state_clr  = 1'b0;
    step_en    = 1'b0;
    ca_out     = 1'b0;
    cb_out     = 1'b0;
    mbit_out   = 1'b0;
    ad_ready   = 1'b0;
    pt_ready   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) next_state = S_CLR;
      end
      S_CLR: begin
        state_clr  = 1'b1;
        next_state = S_INIT;
      end
      S_INIT: begin
        step_en  = 1'b1;
        ca_out   = 1'b1;
        cb_out   = 1'b1;
        mbit_out = init_mbit;
        if (k == INIT_LAST) next_state = (ad_len_q == '0) ? S_AD_PAD : S_AD;
      end
      S_AD: begin
        ad_ready = 1'b1;
        if (ad_valid) begin
          step_en  = 1'b1;
          ca_out   = 1'b1;
          cb_out   = 1'b1;
          mbit_out = ad_bit;
          if (msg_cnt == ad_len_q - 1'b1) next_state = S_AD_PAD;
        end
      end
      S_AD_PAD: begin
        step_en  = 1'b1;
        ca_out   = (k < PAD_CA_END);
        cb_out   = 1'b1;
        mbit_out = (k == '0);
        if (k == PAD_LAST) next_state = (pt_len_q == '0) ? S_ENC_PAD : S_ENC;
      end
      S_ENC: begin
        pt_ready = 1'b1;
        if (pt_valid) begin
          step_en  = 1'b1;
          ca_out   = 1'b1;
          mbit_out = pt_bit;
          if (msg_cnt == pt_len_q - 1'b1) next_state = S_ENC_PAD;
        end
      end
      S_ENC_PAD: begin
        step_en  = 1'b1;
        ca_out   = (k < PAD_CA_END);
        mbit_out = (k == '0);
        if (k == PAD_LAST) next_state = S_FINAL;
      end
      S_FINAL: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
        if (k == FINAL_LAST) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      k        <= '0;
      msg_cnt  <= '0;
      ad_len_q <= '0;
      pt_len_q <= '0;
      tag_q    <= '0;
    end else begin
      state <= next_state;
      // Every phase starts counting from zero, including AD/ENC bit counts.
      if (next_state != state) begin
        k       <= '0;
        msg_cnt <= '0;
      end else if (step_en) begin
        k       <= k + 1'b1;
        msg_cnt <= msg_cnt + 1'b1;
      end
      if ((state == S_IDLE || state == S_DONE) && start) begin
        ad_len_q <= ad_len;
        pt_len_q <= pt_len;
        tag_q    <= '0;
      end
      // The tag is the keystream of the last 128 finalization steps.
      if (state == S_FINAL && k >= TAG_BASE) tag_q[7'(k - TAG_BASE)] <= ks_bit;
    end
  end

  assign ct_bit    = pt_ready & (pt_bit ^ ks_bit);
  assign ct_valid  = pt_ready & pt_valid;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign tag_valid = (state == S_DONE);
  assign tag_out   = tag_q;

endmodule
